// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin packet scheduler sharing one uart_tx among NUM_CH byte streams.
// Latency: request->grant 1 clk, grant->header DV 1 clk, byte handshake->DV 1 clk.
// Backpressure: only the owner sees ready (in LOAD only); ownership lasts until its last byte is sent.
module uart_tx_sched #(
  parameter int         NUM_CH      = 4,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BASE = 8'hA0
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_n,
  input  logic [NUM_CH-1:0]     i_Req_Valid,
  input  logic [8*NUM_CH-1:0]   i_Req_Byte,
  input  logic [NUM_CH-1:0]     i_Req_Last,
  output logic [NUM_CH-1:0]     o_Req_Ready,
  output logic [NUM_CH-1:0]     o_Grant,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active,
  output logic                  o_Busy,
  output logic                  o_Pkt_Done
);

  localparam int IDX_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  rr_next;
  logic              pick_vld;
  int                arb_j;
  logic [NUM_CH-1:0] grant;
  logic [7:0]        byte_q;
  logic              last_q;
  logic              hdr_q;
  logic              armed;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              pkt_done;
  logic              accept;
  logic              load_fire;
  logic              pkt_end;
  logic [7:0]        hdr_byte;

  assign hdr_byte  = HEADER_BASE | 8'(grant_idx);
  // armed records that uart_tx was seen idle since this byte was staged, so a
  // leftover Active from a frame started before reset is not taken as acceptance.
  assign accept    = tx_dv && armed && i_Tx_Active;
  assign load_fire = (state == ST_LOAD) && i_Req_Valid[grant_idx];
  assign pkt_end   = (state == ST_WAIT) && !i_Tx_Active && last_q && !hdr_q;
  assign rr_next   = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  assign o_Grant    = grant;
  assign o_Tx_DV    = tx_dv;
  assign o_Tx_Byte  = tx_byte;
  assign o_Busy     = (state != ST_IDLE);
  assign o_Pkt_Done = pkt_done;

  // Round-robin pick: first valid channel at or above rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    arb_j    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_j = int'(rr_ptr) + i;
      if (arb_j >= NUM_CH) arb_j = arb_j - NUM_CH;
      if (!pick_vld && i_Req_Valid[arb_j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(arb_j);
      end
    end
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and the combinational ready toward the owner.
  always_comb begin
    state_nxt   = state;
    o_Req_Ready = '0;
    case (state)
      ST_IDLE: if (pick_vld) state_nxt = HEADER_EN ? ST_HDR : ST_LOAD;
      ST_HDR,
      ST_SEND: if (accept) state_nxt = ST_WAIT;
      ST_LOAD: begin
        o_Req_Ready[grant_idx] = 1'b1;
        if (i_Req_Valid[grant_idx]) state_nxt = ST_SEND;
      end
      ST_WAIT: if (!i_Tx_Active) state_nxt = (last_q && !hdr_q) ? ST_IDLE : ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant ownership, rotation pointer and packet-done pulse.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      grant     <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (state == ST_IDLE && pick_vld) begin
        grant_idx <= pick_idx;
        grant     <= {{(NUM_CH-1){1'b0}}, 1'b1} << pick_idx;
      end
      if (pkt_end) begin
        pkt_done <= 1'b1;
        rr_ptr   <= rr_next;
        grant    <= '0;
      end
    end
  end

  // Byte capture from the owner; hdr_q marks that the frame in flight is the header.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      byte_q <= 8'h00;
      last_q <= 1'b0;
      hdr_q  <= 1'b0;
    end else if (load_fire) begin
      byte_q <= i_Req_Byte[8*grant_idx +: 8];
      last_q <= i_Req_Last[grant_idx];
      hdr_q  <= 1'b0;
    end else if (state == ST_HDR && accept) begin
      last_q <= 1'b0;
      hdr_q  <= 1'b1;
    end
  end

  // DV/byte toward uart_tx: DV is a level held until Active is seen high.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
      armed   <= 1'b0;
    end else if (state == ST_HDR || state == ST_SEND) begin
      armed <= armed | ~i_Tx_Active;
      if (accept) begin
        tx_dv <= 1'b0;
      end else if (!tx_dv) begin
        tx_dv   <= 1'b1;
        tx_byte <= (state == ST_HDR) ? hdr_byte : byte_q;
      end
    end else begin
      tx_dv <= 1'b0;
      armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural uart_tx model, per-channel packet producers,
// directed scenarios with hand-computed line contents, grant order and handshake timing.
module tb_uart_tx_sched;
  localparam int NCH     = 4;
  localparam int F       = 20;      // uart_tx active clocks per frame in the model
  localparam int GAP_MAX = F + 4;   // frame start-to-start: F active + cleanup + 3
  localparam int BUDGET  = 2000;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [7:0] dly;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]   req_valid = '0;
  logic [NCH-1:0]   req_last  = '0;
  logic [8*NCH-1:0] req_byte  = '0;
  logic [NCH-1:0]   ready, grant;
  logic             dv, busy, done;
  logic [7:0]       txb;

  logic [NCH-1:0]   nh_valid = '0;
  logic [NCH-1:0]   nh_last  = '0;
  logic [8*NCH-1:0] nh_byte  = '0;
  logic [NCH-1:0]   nh_ready, nh_grant;
  logic             nh_dv, nh_busy, nh_done;
  logic [7:0]       nh_txb;

  logic tx_active = 1'b0;
  logic sel_nh    = 1'b0;
  logic line_dv;
  logic [7:0] line_byte;

  int total = 0;
  int bad   = 0;
  int cyc = 0, m_st = 0, m_cnt = 0, frames = 0, dv_rises = 0, viol = 0, done_cnt = 0;
  logic dv_prev = 1'b0;
  logic [7:0] line_q[$];
  int         start_q[$];
  ent_t       chq[NCH][$];

  uart_tx_sched #(.NUM_CH(NCH), .HEADER_EN(1'b1), .HEADER_BASE(8'hA0)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Req_Valid(req_valid), .i_Req_Byte(req_byte), .i_Req_Last(req_last),
    .o_Req_Ready(ready), .o_Grant(grant),
    .o_Tx_DV(dv), .o_Tx_Byte(txb), .i_Tx_Active(tx_active),
    .o_Busy(busy), .o_Pkt_Done(done)
  );

  uart_tx_sched #(.NUM_CH(NCH), .HEADER_EN(1'b0), .HEADER_BASE(8'hA0)) dut_nh (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Req_Valid(nh_valid), .i_Req_Byte(nh_byte), .i_Req_Last(nh_last),
    .o_Req_Ready(nh_ready), .o_Grant(nh_grant),
    .o_Tx_DV(nh_dv), .o_Tx_Byte(nh_txb), .i_Tx_Active(tx_active),
    .o_Busy(nh_busy), .o_Pkt_Done(nh_done)
  );

  assign line_dv   = sel_nh ? nh_dv  : dv;
  assign line_byte = sel_nh ? nh_txb : txb;

  // uart_tx model: accepts DV only when idle, Active for F clocks, one cleanup clock.
  always @(posedge clk) begin
    cyc++;
    case (m_st)
      0: if (line_dv) begin
        tx_active <= 1'b1;
        m_cnt     <= F - 1;
        m_st      <= 1;
        line_q.push_back(line_byte);
        start_q.push_back(cyc);
        frames++;
      end
      1: if (m_cnt == 0) begin
        tx_active <= 1'b0;
        m_st      <= 2;
      end else begin
        m_cnt <= m_cnt - 1;
      end
      default: m_st <= 0;
    endcase
  end

  // Monitors: DV rising edges, done pulses, grant/ready exclusivity.
  always @(negedge clk) begin
    if (line_dv && !dv_prev) dv_rises++;
    dv_prev = line_dv;
    if (done) done_cnt++;
    if ((grant & (grant - 1'b1)) != 0) viol++;
    if ((ready & (ready - 1'b1)) != 0) viol++;
    if ((ready & ~grant) != 0) viol++;
  end

  // Producers: present queue heads, pop after a handshake, honour per-entry pre-delay.
  initial begin
    logic [NCH-1:0] took;
    ent_t e;
    took = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++) begin
        if (took[k] && chq[k].size() > 0) void'(chq[k].pop_front());
        took[k] = 1'b0;
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
        if (chq[k].size() > 0) begin
          e = chq[k][0];
          if (e.dly != 0) begin
            e.dly = e.dly - 8'd1;
            chq[k][0] = e;
          end else begin
            req_valid[k]       = 1'b1;
            req_byte[8*k +: 8] = e.b;
            req_last[k]        = e.last;
          end
        end
        took[k] = req_valid[k] & ready[k];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, bad=%0d", bad);
    $fatal(1);
  end

  task automatic push(input int k, input logic [7:0] b, input logic last, input logic [7:0] dly);
    ent_t e;
    e.b = b; e.last = last; e.dly = dly;
    chq[k].push_back(e);
  endtask

  task automatic wait_size(input int n);
    int c = 0;
    while (line_q.size() < n && c < BUDGET) begin @(negedge clk); c++; end
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    while ((busy || nh_busy || tx_active) && c < BUDGET) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++; if (dv !== 1'b0)   begin bad++; $display("FAIL rst_dv: got %b want 0", dv); end
    total++; if (txb !== 8'h00) begin bad++; $display("FAIL rst_byte: got %h want 00", txb); end
    total++; if (ready !== '0)  begin bad++; $display("FAIL rst_ready: got %b want 0000", ready); end
    total++; if (grant !== '0)  begin bad++; $display("FAIL rst_grant: got %b want 0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_channels();
    logic [7:0] exp[$];
    int base = line_q.size();
    int d0 = done_cnt;
    int v0 = viol;
    exp = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13};
    for (int k = 0; k < NCH; k++) push(k, 8'h10 + 8'(k), 1'b1, 8'd0);
    wait_size(base + exp.size());
    wait_idle();
    total++;
    if (line_q.size() - base !== exp.size()) begin bad++; $display("FAIL all_len: got %0d want %0d", line_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (base + i >= line_q.size() || line_q[base+i] !== exp[i]) begin
        bad++; $display("FAIL all_byte%0d: got %h want %h", i, (base + i < line_q.size()) ? line_q[base+i] : 8'hxx, exp[i]);
      end
    end
    total++; if (done_cnt - d0 !== 4) begin bad++; $display("FAIL all_done: got %0d want 4", done_cnt - d0); end
    total++; if (viol - v0 !== 0) begin bad++; $display("FAIL all_onehot: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_single_ch2();
    logic [7:0] exp[$];
    int base = line_q.size();
    int d0 = done_cnt;
    exp = '{8'hA2, 8'h11, 8'h22};
    push(2, 8'h11, 1'b0, 8'd0);
    push(2, 8'h22, 1'b1, 8'd0);
    wait_size(base + exp.size());
    wait_idle();
    total++;
    if (line_q.size() - base !== exp.size()) begin bad++; $display("FAIL single_len: got %0d want %0d", line_q.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (base + i >= line_q.size() || line_q[base+i] !== exp[i]) begin
        bad++; $display("FAIL single_byte%0d: got %h want %h", i, (base + i < line_q.size()) ? line_q[base+i] : 8'hxx, exp[i]);
      end
    end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done: got %0d want 1", done_cnt - d0); end
    total++; if (grant !== '0) begin bad++; $display("FAIL single_grant_clr: got %b want 0000", grant); end
    // rr_ptr is now 3: with ch1 and ch3 both requesting, ch3 goes first
    base = line_q.size();
    exp = '{8'hA3, 8'h33, 8'hA1, 8'h31};
    push(1, 8'h31, 1'b1, 8'd0);
    push(3, 8'h33, 1'b1, 8'd0);
    wait_size(base + exp.size());
    wait_idle();
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (base + i >= line_q.size() || line_q[base+i] !== exp[i]) begin
        bad++; $display("FAIL rrptr_byte%0d: got %h want %h", i, (base + i < line_q.size()) ? line_q[base+i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_preempt();
    logic [7:0] exp[$];
    int base = line_q.size();
    int c = 0;
    exp = '{8'hA0, 8'hB0, 8'hB1, 8'hB2, 8'hA1, 8'hC1};
    push(0, 8'hB0, 1'b0, 8'd0);
    push(0, 8'hB1, 1'b0, 8'd20);
    push(0, 8'hB2, 1'b1, 8'd0);
    while (chq[0].size() != 2 && c < BUDGET) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    push(1, 8'hC1, 1'b1, 8'd0);
    repeat (2) @(negedge clk);
    total++; if (req_valid[1] !== 1'b1) begin bad++; $display("FAIL preempt_ch1_req: got %b want 1", req_valid[1]); end
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL preempt_grant: got %b want 0001", grant); end
    wait_size(base + exp.size());
    wait_idle();
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (base + i >= line_q.size() || line_q[base+i] !== exp[i]) begin
        bad++; $display("FAIL preempt_byte%0d: got %h want %h", i, (base + i < line_q.size()) ? line_q[base+i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int base = line_q.size();
    int r0 = dv_rises;
    int f0 = frames;
    exp = '{8'hA2, 8'h01, 8'h02, 8'h03, 8'h04};
    push(2, 8'h01, 1'b0, 8'd0);
    push(2, 8'h02, 1'b0, 8'd0);
    push(2, 8'h03, 1'b0, 8'd0);
    push(2, 8'h04, 1'b1, 8'd0);
    wait_size(base + exp.size());
    wait_idle();
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (base + i >= line_q.size() || line_q[base+i] !== exp[i]) begin
        bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, (base + i < line_q.size()) ? line_q[base+i] : 8'hxx, exp[i]);
      end
    end
    for (int i = 1; i < exp.size(); i++) begin
      total++;
      if (base + i >= start_q.size() || start_q[base+i] - start_q[base+i-1] > GAP_MAX) begin
        bad++; $display("FAIL b2b_gap%0d: got %0d clocks want <= %0d", i,
                        (base + i < start_q.size()) ? start_q[base+i] - start_q[base+i-1] : -1, GAP_MAX);
      end
    end
    total++;
    if (dv_rises - r0 !== frames - f0) begin bad++; $display("FAIL b2b_dv_frames: got %0d DV for %0d frames want equal", dv_rises - r0, frames - f0); end
  endtask

  task automatic test_no_header();
    int base = line_q.size();
    int c = 0;
    logic dv_before;
    @(negedge clk);
    sel_nh = 1'b1;
    nh_valid = 4'b0010;
    nh_last  = 4'b0010;
    nh_byte[15:8] = 8'h5A;
    while (!nh_ready[1] && c < BUDGET) begin @(negedge clk); c++; end
    @(negedge clk);
    nh_valid = '0;
    nh_last  = '0;
    dv_before = nh_dv;
    c = 0;
    while (!tx_active && c < BUDGET) begin dv_before = nh_dv; @(negedge clk); c++; end
    total++; if (dv_before !== 1'b1) begin bad++; $display("FAIL nh_dv_pre: got %b want 1", dv_before); end
    total++; if (nh_dv !== 1'b1) begin bad++; $display("FAIL nh_dv_at_active: got %b want 1", nh_dv); end
    @(negedge clk);
    total++; if (nh_dv !== 1'b0) begin bad++; $display("FAIL nh_dv_drop: got %b want 0", nh_dv); end
    wait_idle();
    total++; if (line_q.size() - base !== 1) begin bad++; $display("FAIL nh_len: got %0d want 1", line_q.size() - base); end
    total++;
    if (base >= line_q.size() || line_q[base] !== 8'h5A) begin
      bad++; $display("FAIL nh_byte: got %h want 5a", (base < line_q.size()) ? line_q[base] : 8'hxx);
    end
    total++; if (nh_grant !== '0) begin bad++; $display("FAIL nh_grant_clr: got %b want 0000", nh_grant); end
    sel_nh = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int base = line_q.size();
    int r0, f0;
    push(1, 8'h61, 1'b0, 8'd0);
    push(1, 8'h62, 1'b1, 8'd0);
    wait_size(base + 2);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx_active !== 1'b1) begin bad++; $display("FAIL mid_uart_active: got %b want 1", tx_active); end
    total++; if (dv !== 1'b0)   begin bad++; $display("FAIL mid_rst_dv: got %b want 0", dv); end
    total++; if (txb !== 8'h00) begin bad++; $display("FAIL mid_rst_byte: got %h want 00", txb); end
    total++; if (ready !== '0)  begin bad++; $display("FAIL mid_rst_ready: got %b want 0000", ready); end
    total++; if (grant !== '0)  begin bad++; $display("FAIL mid_rst_grant: got %b want 0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_rst_done: got %b want 0", done); end
    chq[1].delete();
    repeat (3) @(negedge clk);
    base = line_q.size();
    r0 = dv_rises;
    f0 = frames;
    rst_n = 1'b1;
    push(3, 8'h33, 1'b1, 8'd0);
    wait_size(base + 2);
    wait_idle();
    total++; if (line_q.size() - base !== 2) begin bad++; $display("FAIL mid_len: got %0d want 2", line_q.size() - base); end
    total++;
    if (base >= line_q.size() || line_q[base] !== 8'hA3) begin
      bad++; $display("FAIL mid_hdr: got %h want a3", (base < line_q.size()) ? line_q[base] : 8'hxx);
    end
    total++;
    if (base + 1 >= line_q.size() || line_q[base+1] !== 8'h33) begin
      bad++; $display("FAIL mid_data: got %h want 33", (base + 1 < line_q.size()) ? line_q[base+1] : 8'hxx);
    end
    // the header DV waited out the interrupted frame and was taken right after its cleanup clock
    total++;
    if (base >= start_q.size() || start_q[base] - start_q[base-1] !== F + 2) begin
      bad++; $display("FAIL mid_cleanup_hold: got %0d clocks want %0d", (base < start_q.size()) ? start_q[base] - start_q[base-1] : -1, F + 2);
    end
    total++;
    if (dv_rises - r0 !== frames - f0) begin bad++; $display("FAIL mid_dv_frames: got %0d DV for %0d frames want equal", dv_rises - r0, frames - f0); end
  endtask

  initial begin
    test_reset();
    test_all_channels();
    test_single_ch2();
    test_preempt();
    test_back_to_back();
    test_no_header();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
